aes_key_schedule: RTL and testbench

AES_KEY_SCHEDULE -- requirements
Module: aes_key_schedule

---
 rtl/aes_pkg.sv | 36 +++
 rtl/aes_sub_word.sv | 35 +++
 rtl/aes_key_schedule.sv | 110 +++++++++++
 tb/tb_aes_key_schedule.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: key/round sizes, round-constant table and key-schedule FSM states.
package aes_pkg;

    localparam int unsigned NK     = 8;
    localparam int unsigned NR     = 14;
    localparam int unsigned NW     = 4 * (NR + 1);
    localparam int unsigned WORD_W = 32;
    localparam int unsigned KEY_W  = WORD_W * NK;
    localparam int unsigned RK_W   = 4 * WORD_W;
    localparam int unsigned IDX_W  = 6;
    localparam int unsigned RKI_W  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } ks_state_e;

    // Rcon[r] high byte; only r = 1..7 is used by AES-256.
    function automatic logic [7:0] rcon(input logic [2:0] r);
        logic [7:0] v;
        v = 8'h00;
        case (r)
            3'd1: v = 8'h01;
            3'd2: v = 8'h02;
            3'd3: v = 8'h04;
            3'd4: v = 8'h08;
            3'd5: v = 8'h10;
            3'd6: v = 8'h20;
            3'd7: v = 8'h40;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: four parallel combinational FIPS-197 S-box lookups on a 32-bit word.
module aes_sub_word
    import aes_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    output logic [WORD_W-1:0] sub_word_c
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    always_comb begin
        sub_word_c = '0;
        for (int b = 0; b < 4; b++) begin
            sub_word_c[8*b +: 8] = SBOX[word[8*b +: 8]];
        end
    end

endmodule

// File: rtl/aes_key_schedule.sv
// AES-256 key expansion: one schedule word per cycle into a 60-word array, round keys read combinationally.
module aes_key_schedule #(
    parameter int unsigned NK = aes_pkg::NK,
    parameter int unsigned NR = aes_pkg::NR
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 key_valid,
    output logic                 key_ready,
    input  logic [32*NK-1:0]     key,
    input  logic [3:0]           rk_idx,
    output logic [127:0]         rk,
    output logic                 sched_done,
    output logic                 busy
);

    import aes_pkg::WORD_W;
    import aes_pkg::IDX_W;
    import aes_pkg::ks_state_e;
    import aes_pkg::IDLE;
    import aes_pkg::EXPAND;
    import aes_pkg::DONE;
    import aes_pkg::rcon;

    localparam int unsigned NWORDS = 4 * (NR + 1);
    localparam logic [IDX_W-1:0] LAST_I = IDX_W'(NWORDS - 1);

    ks_state_e          state;
    logic [IDX_W-1:0]   i;
    logic [WORD_W-1:0]  w [NWORDS];

    logic [WORD_W-1:0]  w_prev;
    logic [WORD_W-1:0]  w_back;
    logic [WORD_W-1:0]  sw_in;
    logic [WORD_W-1:0]  sw_out;
    logic [WORD_W-1:0]  t;
    logic [WORD_W-1:0]  w_new;
    logic [IDX_W-1:0]   base;

    // Next schedule word; RotWord only feeds the S-box on the i%8 == 0 step, so one SubWord suffices.
    always_comb begin
        w_prev = w[i - IDX_W'(1)];
        w_back = w[i - IDX_W'(NK)];
        sw_in  = (i[2:0] == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
        case (i[2:0])
            3'd0:    t = sw_out ^ {rcon(i[5:3]), 24'h0};
            3'd4:    t = sw_out;
            default: t = w_prev;
        endcase
        w_new = w_back ^ t;
    end

    aes_sub_word u_sub_word (
        .word       (sw_in),
        .sub_word_c (sw_out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            i          <= '0;
            key_ready  <= 1'b1;
            busy       <= 1'b0;
            sched_done <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (key_valid && key_ready) begin
                        for (int j = 0; j < int'(NK); j++) begin
                            w[j] <= key[32*NK-1-32*j -: 32];
                        end
                        i          <= IDX_W'(NK);
                        state      <= EXPAND;
                        key_ready  <= 1'b0;
                        busy       <= 1'b1;
                        sched_done <= 1'b0;
                    end
                end
                EXPAND: begin
                    w[i] <= w_new;
                    if (i == LAST_I) begin
                        state      <= DONE;
                        key_ready  <= 1'b1;
                        busy       <= 1'b0;
                        sched_done <= 1'b1;
                    end else begin
                        i <= i + IDX_W'(1);
                    end
                end
                default: begin
                    state      <= IDLE;
                    i          <= '0;
                    key_ready  <= 1'b1;
                    busy       <= 1'b0;
                    sched_done <= 1'b0;
                end
            endcase
        end
    end

    // Round-key read, gated to zero until the schedule is complete or for an illegal index.
    always_comb begin
        base = {rk_idx, 2'b00};
        rk   = '0;
        if (sched_done && (rk_idx <= 4'(NR))) begin
            rk = {w[base], w[base + IDX_W'(1)], w[base + IDX_W'(2)], w[base + IDX_W'(3)]};
        end
    end

endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed bench for aes_key_schedule using FIPS-197 A.3 and all-zero key vectors.
module tb_aes_key_schedule;

    logic         clk;
    logic         reset;
    logic         key_valid;
    logic         key_ready;
    logic [255:0] key;
    logic [3:0]   rk_idx;
    logic [127:0] rk;
    logic         sched_done;
    logic         busy;

    int n_tests;
    int n_fail;

    localparam logic [255:0] KEY_A3   = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [255:0] KEY_ZERO = 256'h0;
    localparam logic [255:0] KEY_ALT  = {8{32'hdeadbeef}};

    aes_key_schedule dut (
        .clk        (clk),
        .reset      (reset),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key        (key),
        .rk_idx     (rk_idx),
        .rk         (rk),
        .sched_done (sched_done),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic read_rk(input logic [3:0] idx, output logic [127:0] v);
        rk_idx = idx;
        #1;
        v = rk;
    endtask

    // Handshake a key, optionally keep offering another key during expansion, and time completion.
    task automatic run_key(input logic [255:0] k, input bit hold, input string tag,
                           output int cycles, output int ready_low);
        @(negedge clk);
        key       = k;
        key_valid = 1'b1;
        @(posedge clk);
        #1;
        if (hold) key = KEY_ALT;
        else      key_valid = 1'b0;
        check({tag, "_done_drop"}, 128'(sched_done), 128'd0);
        check({tag, "_busy"}, 128'(busy), 128'd1);
        cycles    = 0;
        ready_low = 0;
        while (!sched_done && cycles < 100) begin
            if (!key_ready) ready_low++;
            @(posedge clk);
            #1;
            cycles++;
        end
        key_valid = 1'b0;
        check({tag, "_latency"}, 128'(cycles), 128'd52);
    endtask

    logic [127:0] v;
    int cyc;
    int rlow;

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        reset     = 1'b1;
        key_valid = 1'b0;
        key       = '0;
        rk_idx    = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_key_ready", 128'(key_ready), 128'd1);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_done", 128'(sched_done), 128'd0);
        check("rst_rk", rk, 128'h0);

        // Reset wins over a simultaneous handshake.
        @(negedge clk);
        key       = KEY_A3;
        key_valid = 1'b1;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        check("rst_prio_busy", 128'(busy), 128'd0);
        check("rst_prio_ready", 128'(key_ready), 128'd1);
        @(negedge clk);
        reset = 1'b0;

        // FIPS-197 A.3 vector.
        run_key(KEY_A3, 1'b0, "a3", cyc, rlow);
        check("a3_ready_low", 128'(rlow), 128'd52);
        read_rk(4'd0, v);
        check("a3_rk0", v, KEY_A3[255:128]);
        read_rk(4'd1, v);
        check("a3_rk1", v, 128'h1f352c073b6108d72d9810a30914dff4);
        read_rk(4'd2, v);
        check("a3_w8", 128'(v[127:96]), 128'h9ba35411);
        read_rk(4'd14, v);
        check("a3_rk14", v, 128'hfe4890d1e6188d0b046df344706c631e);
        read_rk(4'd15, v);
        check("a3_rk15_zero", v, 128'h0);

        // New key presented in DONE restarts with the zero key.
        run_key(KEY_ZERO, 1'b0, "zero", cyc, rlow);
        read_rk(4'd2, v);
        check("zero_rk2", v, {4{32'h62636363}});
        read_rk(4'd3, v);
        check("zero_rk3", v, {4{32'haafbfbfb}});

        // A different key held valid through expansion must not disturb it.
        run_key(KEY_A3, 1'b1, "hold", cyc, rlow);
        check("hold_ready_low", 128'(rlow), 128'd52);
        read_rk(4'd1, v);
        check("hold_rk1", v, 128'h1f352c073b6108d72d9810a30914dff4);
        read_rk(4'd14, v);
        check("hold_rk14", v, 128'hfe4890d1e6188d0b046df344706c631e);

        // Abort expansion with reset at cycle 20, then rerun A.3.
        @(negedge clk);
        key       = KEY_ZERO;
        key_valid = 1'b1;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        check("abort_busy_before", 128'(busy), 128'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort_busy", 128'(busy), 128'd0);
        check("abort_ready", 128'(key_ready), 128'd1);
        check("abort_done", 128'(sched_done), 128'd0);
        read_rk(4'd1, v);
        check("abort_rk", v, 128'h0);
        repeat (3) @(posedge clk);
        #1;
        check("abort_stays_idle", 128'(busy), 128'd0);

        run_key(KEY_A3, 1'b0, "rerun", cyc, rlow);
        read_rk(4'd1, v);
        check("rerun_rk1", v, 128'h1f352c073b6108d72d9810a30914dff4);
        read_rk(4'd14, v);
        check("rerun_rk14", v, 128'hfe4890d1e6188d0b046df344706c631e);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
